chi_stage: RTL and testbench

- Slice-serial chi step of the round datapath; sits directly upstream of the round-constant (iota) stage.
- Sweeps all 64 25-bit slices of state memory and applies the chi nonlinearity per slice: a[x][y] ^= (~a[x+1][y]) & a[x+2][y].
- Writes each result slice back to the same address.
- Signals done so the controller can launch the round-constant stage.

---
 rtl/chi_stage.sv | 109 ++++++++++
 tb/tb_chi_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/chi_stage.sv
// chi_stage: slice-serial chi step. Reads each 25-bit slice, applies
// a[x][y] ^= ~a[x+1][y] & a[x+2][y] row by row, and writes it back in place.
module chi_stage #(
  parameter int unsigned SLICES = 64,
  parameter int unsigned AW     = 6,
  parameter int unsigned W      = 25
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [W-1:0]  rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [W-1:0]  wr_data,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(SLICES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [AW-1:0] rd_cnt;
  logic          rd_vld_q;
  logic [AW-1:0] rd_addr_q;

  // Chi on one slice; each 5-bit row (fixed y) is transformed independently.
  function automatic logic [W-1:0] chi(input logic [W-1:0] a);
    logic [W-1:0] r;
    r = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        r[5*y + x] = a[5*y + x] ^ (~a[5*y + ((x + 1) % 5)] & a[5*y + ((x + 2) % 5)]);
      end
    end
    return r;
  endfunction

  // Sweep control plus two-stage read -> chi -> write pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rd_cnt    <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rd_vld_q  <= rd_en;
      rd_addr_q <= rd_addr;
      wr_en     <= rd_vld_q;
      if (rd_vld_q) begin
        wr_addr <= rd_addr_q;
        wr_data <= chi(rd_data);
      end
      done <= 1'b0;

      case (state)
        IDLE: begin
          rd_en <= 1'b0;
          if (start) begin
            state  <= RUN;
            rd_cnt <= '0;
          end
        end
        RUN: begin
          rd_en   <= 1'b1;
          rd_addr <= rd_cnt;
          busy    <= 1'b1;
          if (rd_cnt == LAST_ADDR) begin
            state <= DRAIN;
          end else begin
            rd_cnt <= rd_cnt + AW'(1);
          end
        end
        DRAIN: begin
          rd_en <= 1'b0;
          if (wr_en && (wr_addr == LAST_ADDR)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          rd_en <= 1'b0;
          state <= IDLE;
        end
        default: begin
          rd_en <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chi_stage.sv
// Testbench for chi_stage: memory model with read latency 1, cycle-exact
// expectations derived from the pass timeline, and a row-rotation chi model.
module tb_chi_stage;

  localparam int unsigned SLICES = 64;
  localparam int unsigned AW     = 6;
  localparam int unsigned W      = 25;

  logic          clk;
  logic          rst;
  logic          start;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          busy;
  logic          done;

  logic [W-1:0] mem [SLICES];

  int total;
  int bad;

  chi_stage #(.SLICES(SLICES), .AW(AW), .W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slice memory: data appears one cycle after the read strobe; garbage otherwise.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    else       rd_data <= W'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Chi reference: each row is a 5-bit word; neighbours are obtained by rotation.
  function automatic logic [W-1:0] ref_chi(input logic [W-1:0] s);
    int unsigned res;
    int unsigned row, nb1, nb2;
    res = 0;
    for (int y = 0; y < 5; y++) begin
      row = (int'(s) >> (5 * y)) & 31;
      nb1 = ((row >> 1) | (row << 4)) & 31;
      nb2 = ((row >> 2) | (row << 3)) & 31;
      res = res | (((row ^ (~nb1 & nb2)) & 31) << (5 * y));
    end
    return W'(res);
  endfunction

  // Expected outputs in cycle k of a pass (k = 0 is the cycle after start is sampled).
  task automatic check_cycle(input int k);
    bit e_rd, e_wr;
    e_rd = (k >= 1) && (k <= SLICES);
    e_wr = (k >= 3) && (k <= SLICES + 2);
    chk($sformatf("rd_en[%0d]", k), 32'(rd_en), 32'(e_rd));
    if (e_rd) chk($sformatf("rd_addr[%0d]", k), 32'(rd_addr), 32'(k - 1));
    if (k > SLICES && k <= SLICES + 2) chk($sformatf("rd_addr_hold[%0d]", k), 32'(rd_addr), 32'(SLICES - 1));
    chk($sformatf("wr_en[%0d]", k), 32'(wr_en), 32'(e_wr));
    if (e_wr) begin
      chk($sformatf("wr_addr[%0d]", k), 32'(wr_addr), 32'(k - 3));
      chk($sformatf("wr_data[%0d]", k), 32'(wr_data), 32'(ref_chi(mem[k - 3])));
    end
    chk($sformatf("busy[%0d]", k), 32'(busy), 32'((k >= 1) && (k <= SLICES + 2)));
    chk($sformatf("done[%0d]", k), 32'(done), 32'(k == SLICES + 3));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_en"},   32'(rd_en),   32'd0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_wr_en"},   32'(wr_en),   32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_busy"},    32'(busy),    32'd0);
    chk({tag, "_done"},    32'(done),    32'd0);
  endtask

  // One pass from IDLE. Optional stray start pulses; optional reset at cycle rst_at.
  task automatic run_pass(input int last_k, input bit pulse_mode, input int rst_at);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      check_cycle(k);
      if (k == rst_at) begin
        #2 rst = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      start = pulse_mode && (k == 10 || k == 40 || k == SLICES + 3);
    end
    start = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < SLICES; i++) mem[i] = W'($urandom);
  endtask

  initial begin
    int strobes;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < SLICES; i++) mem[i] = '0;

    // Asynchronous reset before any clock edge.
    #3 rst = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Idle with no start: no strobes at all.
    strobes = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd_en || wr_en || busy || done) strobes++;
    end
    chk("idle_strobes", 32'(strobes), 32'd0);

    // All-zero memory.
    run_pass(72, 1'b0, 0);

    // Single-bit patterns.
    mem[0]  = 25'h0000001;
    mem[1]  = 25'h0000002;
    mem[63] = 25'h1FFFFFF;
    chk("chi_ref_bit0", 32'(ref_chi(mem[0])), 32'h0000009);
    chk("chi_ref_bit1", 32'(ref_chi(mem[1])), 32'h0000012);
    chk("chi_ref_ones", 32'(ref_chi(mem[63])), 32'h1FFFFFF);
    run_pass(72, 1'b0, 0);

    // Random memory, two passes.
    fill_random();
    run_pass(72, 1'b0, 0);
    fill_random();
    run_pass(72, 1'b0, 0);

    // Stray start pulses at cycles 10, 40, 67: exactly one pass, then quiet.
    fill_random();
    run_pass(75, 1'b1, 0);

    // Reset at cycle 30, then a fresh full pass.
    fill_random();
    run_pass(40, 1'b0, 30);
    check_all_zero("post_reset");
    run_pass(72, 1'b0, 0);

    // start held high: next pass reads from cycle 70 (DONE + one IDLE cycle).
    fill_random();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= SLICES + 6; k++) begin
      @(negedge clk);
      if (k <= SLICES + 5) begin
        check_cycle(k);
      end else begin
        chk("hold_rd_en",   32'(rd_en),   32'd1);
        chk("hold_rd_addr", 32'(rd_addr), 32'd0);
        chk("hold_busy",    32'(busy),    32'd1);
      end
    end
    start = 1'b0;
    for (int i = 0; i < 80; i++) @(negedge clk);
    chk("hold_end_busy",  32'(busy),  32'd0);
    chk("hold_end_rd_en", 32'(rd_en), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
